jam_cost_host: RTL and testbench
================================

Name: jam_cost_host

Overview:
- Host/feeder stage directly upstream of the JAM job-assignment core.
- Loads the 8x8 cost table (64 x 7-bit) from a valid/ready stream and serves it to JAM as a combinational cost ROM (Cost = table[8*W+J]).
- Holds JAM in reset until the table is complete, then releases it and captures JAM's MinCost/MatchCount on Valid.
- Provides a watchdog timeout on the JAM run.

Parameters:
- RST_HOLD, 2, cycles jam_rst stays high after entering RUN (min 1).
- TIMEOUT, 1000000, max cycles in RUN (counted after jam_rst release) before aborting with res_error.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, synchronous, active-high
- load_start  in  1  single-cycle pulse; (re)starts a table load from entry 0
- in_valid  in  1  cost beat valid
- in_cost  in  7  cost beat, row-major: beat k = worker k/8, job k%8
- in_ready  out  1  high only in LOAD
- W  in  3  worker index from JAM
- J  in  3  job index from JAM
- Cost  out  7  table[{W,J}], combinational, any state
- jam_rst  out  1  reset to JAM core
- jam_valid  in  1  JAM Valid
- jam_min_cost  in  9  JAM MinCost
- jam_match_count  in  4  JAM MatchCount
- res_valid  out  1  result held valid (DONE)
- res_error  out  1  timeout occurred (valid with res_valid)
- res_min_cost  out  9  captured MinCost
- res_match_count  out  4  captured MatchCount
- busy  out  1  state is LOAD or RUN

Behaviour:
- Reset (RST=1 at edge): state IDLE, cnt=0, hold_cnt=0, tmo_cnt=0, in_ready=0, jam_rst=1, res_valid=0, res_error=0, res_min_cost=0, res_match_count=0, busy=0. Table storage is not reset; Cost is undefined until the first complete load.
- States:
  - IDLE: jam_rst=1. load_start -> LOAD.
  - LOAD: in_ready=1 (registered, high from the first LOAD cycle). A beat is accepted when in_valid&in_ready: table[cnt]<=in_cost, cnt++. Accepting beat cnt==63 -> RUN with hold_cnt=0; in_ready low the next cycle. Exactly 64 beats are accepted per load, with no gaps required.
  - RUN: jam_rst=1 while hold_cnt<RST_HOLD (hold_cnt increments each cycle), then 0. After release, tmo_cnt increments each cycle.
    - jam_valid=1 with jam_rst=0 -> capture jam_min_cost/jam_match_count into res_*, res_valid=1, res_error=0, -> DONE.
    - jam_valid while jam_rst=1 is ignored.
    - tmo_cnt reaching TIMEOUT-1 without jam_valid -> res_valid=1, res_error=1, res_* = 0, -> DONE.
    - jam_valid in the same cycle as the timeout: capture wins, res_error=0.
  - DONE: jam_rst=1. res_* held stable until the next load_start.
- load_start is honoured in every state (IDLE/LOAD/RUN/DONE): next state LOAD, cnt=0, tmo_cnt=0, res_valid=0, res_error=0, jam_rst=1. It takes priority over a simultaneous beat acceptance (that beat is dropped) and over a simultaneous jam_valid/timeout.
- Cost read is pure combinational from the storage array. A write to table[{W,J}] becomes visible on Cost the cycle after acceptance.
- busy=1 in LOAD and RUN. Output latency: res_valid rises 1 cycle after the jam_valid edge.
- RST mid-LOAD/RUN: immediate return to reset values at the next edge. Table content is retained but must be reloaded.
- Counter widths: cnt 6 bits (wraps only through the state change), hold_cnt $clog2(RST_HOLD+1), tmo_cnt $clog2(TIMEOUT).

Decomposition:
- Package jam_pkg: N_WORKER=8, COST_W=7, MINCOST_W=9, MATCH_W=4, TBL_DEPTH=64, state enum {IDLE, LOAD, RUN, DONE}.
- One sub-module, jam_cost_table: 64x7 register array with single write port (we, waddr[5:0], wdata) and combinational read port (raddr={W,J}).
- FSM, counters and result capture live in jam_cost_host.

Test Plan:
- Reset then load 64 beats with cost k%100 and in_valid always high -> in_ready high for exactly 64 cycles. Then drive W=3,J=5 -> Cost=29. jam_rst stays 1 for RST_HOLD=2 cycles in RUN, then 0.
- Load with in_valid toggling every other cycle -> still exactly 64 accepts; table[63] correct; RUN entered the cycle after the 64th accept.
- In RUN, pulse jam_valid with MinCost=9'd214, MatchCount=4'd3 -> next cycle res_valid=1, res_error=0, res_min_cost=214, res_match_count=3, jam_rst=1. Values held for 100 cycles.
- TIMEOUT=50, never assert jam_valid -> res_valid=1, res_error=1 exactly 50 cycles after jam_rst release. jam_valid in that same cycle -> res_error=0 with captured values.
- load_start at beat 30 of a load -> cnt restarts. Beat accepted in the load_start cycle is dropped; 64 further beats are required before RUN.
- jam_valid asserted during the jam_rst hold window -> ignored, state stays RUN; RST asserted mid-RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/jam_pkg.sv
// Shared constants and types for the JAM cost host and its cost table.
package jam_pkg;

    localparam int N_WORKER  = 8;
    localparam int IDX_W     = 3;
    localparam int COST_W    = 7;
    localparam int MINCOST_W = 9;
    localparam int MATCH_W   = 4;
    localparam int TBL_DEPTH = N_WORKER * N_WORKER;
    localparam int ADDR_W    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Row-major table address: worker selects the row, job the column.
    function automatic logic [ADDR_W-1:0] tbl_addr(
        input logic [IDX_W-1:0] w,
        input logic [IDX_W-1:0] j
    );
        return {w, j};
    endfunction

endpackage

// File: rtl/jam_cost_table.sv
// 64 x 7-bit cost storage: one synchronous write port, one combinational read port.
module jam_cost_table
    import jam_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [COST_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [COST_W-1:0] rdata
);

    logic [COST_W-1:0] mem_r [TBL_DEPTH];

    // Storage is deliberately not reset; contents are only meaningful after a full load.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/jam_cost_host.sv
// Feeds the JAM core: streams in the cost table, sequences JAM reset, captures the result with a watchdog.
module jam_cost_host
    import jam_pkg::*;
#(
    parameter int RST_HOLD = 2,
    parameter int TIMEOUT  = 1000000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 load_start,
    input  logic                 in_valid,
    input  logic [COST_W-1:0]    in_cost,
    output logic                 in_ready,
    input  logic [IDX_W-1:0]     W,
    input  logic [IDX_W-1:0]     J,
    output logic [COST_W-1:0]    Cost,
    output logic                 jam_rst,
    input  logic                 jam_valid,
    input  logic [MINCOST_W-1:0] jam_min_cost,
    input  logic [MATCH_W-1:0]   jam_match_count,
    output logic                 res_valid,
    output logic                 res_error,
    output logic [MINCOST_W-1:0] res_min_cost,
    output logic [MATCH_W-1:0]   res_match_count,
    output logic                 busy
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int TMO_W  = $clog2(TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] BEAT_LAST = ADDR_W'(TBL_DEPTH - 1);

    state_t                 state_r;
    logic [ADDR_W-1:0]      cnt_r;
    logic [HOLD_W-1:0]      hold_cnt_r;
    logic [TMO_W-1:0]       tmo_cnt_r;
    logic                   in_ready_r;
    logic                   jam_rst_r;
    logic                   res_valid_r;
    logic                   res_error_r;
    logic [MINCOST_W-1:0]   res_min_cost_r;
    logic [MATCH_W-1:0]     res_match_count_r;
    logic                   busy_r;
    logic                   accept_s;
    logic [HOLD_W-1:0]      hold_next_s;

    // Beat acceptance; a simultaneous load_start discards the beat.
    always_comb begin
        accept_s    = 1'b0;
        hold_next_s = hold_cnt_r + HOLD_W'(1);
        if ((state_r == LOAD) && in_valid && in_ready_r && !load_start) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    jam_cost_table u_table (
        .clk   (CLK),
        .we    (accept_s),
        .waddr (cnt_r),
        .wdata (in_cost),
        .raddr (tbl_addr(W, J)),
        .rdata (Cost)
    );

    // Sequencer: load, JAM reset hold, watchdog run, result capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r           <= IDLE;
            cnt_r             <= '0;
            hold_cnt_r        <= '0;
            tmo_cnt_r         <= '0;
            in_ready_r        <= 1'b0;
            jam_rst_r         <= 1'b1;
            res_valid_r       <= 1'b0;
            res_error_r       <= 1'b0;
            res_min_cost_r    <= '0;
            res_match_count_r <= '0;
            busy_r            <= 1'b0;
        end else if (load_start) begin
            state_r     <= LOAD;
            cnt_r       <= '0;
            hold_cnt_r  <= '0;
            tmo_cnt_r   <= '0;
            in_ready_r  <= 1'b1;
            jam_rst_r   <= 1'b1;
            res_valid_r <= 1'b0;
            res_error_r <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    jam_rst_r <= 1'b1;
                end
                LOAD: begin
                    if (accept_s) begin
                        cnt_r <= cnt_r + ADDR_W'(1);
                        if (cnt_r == BEAT_LAST) begin
                            state_r    <= RUN;
                            hold_cnt_r <= '0;
                            tmo_cnt_r  <= '0;
                            in_ready_r <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (hold_cnt_r < HOLD_LAST) begin
                        // JAM still held in reset; its Valid is not trusted yet.
                        hold_cnt_r <= hold_next_s;
                        jam_rst_r  <= (hold_next_s < HOLD_LAST);
                    end else if (jam_valid) begin
                        state_r           <= DONE;
                        jam_rst_r         <= 1'b1;
                        busy_r            <= 1'b0;
                        res_valid_r       <= 1'b1;
                        res_error_r       <= 1'b0;
                        res_min_cost_r    <= jam_min_cost;
                        res_match_count_r <= jam_match_count;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        state_r           <= DONE;
                        jam_rst_r         <= 1'b1;
                        busy_r            <= 1'b0;
                        res_valid_r       <= 1'b1;
                        res_error_r       <= 1'b1;
                        res_min_cost_r    <= '0;
                        res_match_count_r <= '0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                DONE: begin
                    jam_rst_r <= 1'b1;
                end
                default: begin
                    state_r    <= IDLE;
                    jam_rst_r  <= 1'b1;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready        = in_ready_r;
    assign jam_rst         = jam_rst_r;
    assign res_valid       = res_valid_r;
    assign res_error       = res_error_r;
    assign res_min_cost    = res_min_cost_r;
    assign res_match_count = res_match_count_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_jam_cost_host.sv
// Directed bench for jam_cost_host with an age-based reference model checked every cycle.
module tb_jam_cost_host;

    localparam int RST_HOLD = 2;
    localparam int TIMEOUT  = 50;

    logic       clk = 1'b0;
    logic       RST, load_start, in_valid, in_ready;
    logic [6:0] in_cost, Cost;
    logic [2:0] W, J;
    logic       jam_rst, jam_valid, res_valid, res_error, busy;
    logic [8:0] jam_min_cost, res_min_cost;
    logic [3:0] jam_match_count, res_match_count;

    jam_cost_host #(.RST_HOLD(RST_HOLD), .TIMEOUT(TIMEOUT)) dut (
        .CLK(clk), .RST(RST), .load_start(load_start), .in_valid(in_valid),
        .in_cost(in_cost), .in_ready(in_ready), .W(W), .J(J), .Cost(Cost),
        .jam_rst(jam_rst), .jam_valid(jam_valid), .jam_min_cost(jam_min_cost),
        .jam_match_count(jam_match_count), .res_valid(res_valid), .res_error(res_error),
        .res_min_cost(res_min_cost), .res_match_count(res_match_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: table contents plus a single "age in RUN" counter.
    int tbl [64];
    bit known [64];
    bit m_loading, m_running, m_rv, m_re;
    int m_beats, m_age, m_rmc, m_rmatch;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        if (RST) begin
            m_loading = 0; m_running = 0; m_rv = 0; m_re = 0; m_rmc = 0; m_rmatch = 0;
        end else if (load_start) begin
            m_loading = 1; m_running = 0; m_beats = 0; m_rv = 0; m_re = 0;
        end else if (m_loading) begin
            if (in_valid) begin
                tbl[m_beats] = in_cost;
                known[m_beats] = 1;
                m_beats++;
                if (m_beats == 64) begin
                    m_loading = 0; m_running = 1; m_age = 0;
                end
            end
        end else if (m_running) begin
            if (m_age >= RST_HOLD && jam_valid) begin
                m_running = 0; m_rv = 1; m_re = 0;
                m_rmc = jam_min_cost; m_rmatch = jam_match_count;
            end else if (m_age - RST_HOLD == TIMEOUT - 1) begin
                m_running = 0; m_rv = 1; m_re = 1; m_rmc = 0; m_rmatch = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic model_check();
        chk("in_ready", in_ready, m_loading);
        chk("busy", busy, m_loading || m_running);
        chk("jam_rst", jam_rst, !(m_running && m_age >= RST_HOLD));
        chk("res_valid", res_valid, m_rv);
        if (m_rv) begin
            chk("res_error", res_error, m_re);
            chk("res_min_cost", res_min_cost, m_rmc);
            chk("res_match_count", res_match_count, m_rmatch);
        end
        if (known[{W, J}]) chk("cost", Cost, tbl[{W, J}]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        model_check();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_jam_rst"}, jam_rst, 1);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_error"}, res_error, 0);
        chk({tag, "_res_min_cost"}, res_min_cost, 0);
        chk({tag, "_res_match_count"}, res_match_count, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        RST = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_cost = 7'd0;
        W = 3'd0; J = 3'd0; jam_valid = 1'b0; jam_min_cost = 9'd0; jam_match_count = 4'd0;
        tick(); tick();
        chk_reset_values("reset");
        RST = 1'b0;
        tick();

        // Load 1: continuous beats k%100.
        load_start = 1'b1; tick(); load_start = 1'b0;
        n = in_ready ? 1 : 0;
        in_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            in_cost = 7'(k % 100);
            tick();
            if (in_ready) n++;
        end
        in_valid = 1'b0;
        chk("ready_cycles", n, 64);
        chk("jam_rst_run0", jam_rst, 1);
        W = 3'd3; J = 3'd5;
        jam_valid = 1'b1; jam_min_cost = 9'd77; jam_match_count = 4'd1;
        tick();
        chk("cost_w3j5", Cost, 29);
        chk("jam_rst_run1", jam_rst, 1);
        tick();
        jam_valid = 1'b0;
        chk("jam_rst_released", jam_rst, 0);
        chk("hold_valid_ignored", res_valid, 0);
        chk("hold_still_busy", busy, 1);
        tick(); tick(); tick();
        jam_valid = 1'b1; jam_min_cost = 9'd214; jam_match_count = 4'd3;
        tick();
        jam_valid = 1'b0;
        chk("cap_res_valid", res_valid, 1);
        chk("cap_res_error", res_error, 0);
        chk("cap_min_cost", res_min_cost, 214);
        chk("cap_match", res_match_count, 3);
        chk("cap_jam_rst", jam_rst, 1);
        for (int i = 0; i < 100; i++) begin
            jam_valid = (i % 3 == 0);
            jam_min_cost = 9'(i); jam_match_count = 4'(i);
            tick();
        end
        jam_valid = 1'b0;
        chk("held_min_cost", res_min_cost, 214);
        chk("held_match", res_match_count, 3);

        // Load 2: in_valid toggling, values 127-beat; then pure timeout.
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int c = 0; c < 200 && m_loading; c++) begin
            in_valid = (c % 2 == 0);
            in_cost = 7'(127 - m_beats);
            tick();
        end
        in_valid = 1'b0;
        chk("toggle_ready_low", in_ready, 0);
        chk("toggle_run_busy", busy, 1);
        W = 3'd7; J = 3'd7;
        tick();
        chk("cost_w7j7", Cost, 64);
        for (int c = 0; c < 10 && jam_rst; c++) tick();
        n = 0;
        while (!res_valid && n < 200) begin
            tick();
            n++;
        end
        chk("tmo_latency", n, 50);
        chk("tmo_error", res_error, 1);
        chk("tmo_min_cost", res_min_cost, 0);

        // Load 3: restart at beat 30 (that beat dropped), then capture on the timeout cycle.
        load_start = 1'b1; tick(); load_start = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            in_cost = 7'(100 + k);
            tick();
        end
        load_start = 1'b1; in_cost = 7'd111; tick(); load_start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            in_cost = 7'((k * 3) % 128);
            tick();
            if (k == 62) chk("ready_before_last", in_ready, 1);
        end
        in_valid = 1'b0;
        chk("restart_ready_low", in_ready, 0);
        W = 3'd2; J = 3'd1;
        tick();
        chk("cost_restart", Cost, 51);
        for (int c = 0; c < 10 && jam_rst; c++) tick();
        for (int i = 0; i < 49; i++) tick();
        jam_valid = 1'b1; jam_min_cost = 9'd300; jam_match_count = 4'd9;
        tick();
        jam_valid = 1'b0;
        chk("race_res_valid", res_valid, 1);
        chk("race_res_error", res_error, 0);
        chk("race_min_cost", res_min_cost, 300);
        chk("race_match", res_match_count, 9);

        // Load 4: RST in the middle of RUN.
        load_start = 1'b1; tick(); load_start = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            in_cost = 7'(k ^ 85);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        RST = 1'b1;
        tick();
        chk_reset_values("midrun_rst");
        RST = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
